// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the console UART transmitter.
//   wr_data : byte to enqueue
//   wr_en   : enqueue strobe, sampled on the rising clock edge
//   full    : FIFO holds DEPTH entries (registered-state decode)
//   empty   : FIFO holds no entries (registered-state decode)
// master = producer (CPU/debug logic), slave = uart_tx_fifo.
interface uart_tx_fifo_if;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;

  modport master (
    output wr_data,
    output wr_en,
    input  full,
    input  empty
  );

  modport slave (
    input  wr_data,
    input  wr_en,
    output full,
    output empty
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a small write FIFO (serial console TX path).
// Ports:
//   clock_50_b7a : system clock, rising edge
//   reset        : asynchronous, active-high; aborts any frame in flight
//   wif          : write bus (wr_data, wr_en in; full, empty out)
//   busy         : shifter is in START, DATA or STOP
//   tx           : serial line, idle high, driven from a flop
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic           clock_50_b7a,
  input  logic           reset,
  uart_tx_fifo_if.slave  wif,
  output logic           busy,
  output logic           tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned DEPTH        = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W        = DEPTH_LOG2 + 1;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [LVL_W-1:0]      count;
  state_t                state;
  logic [CNT_W-1:0]      baud_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shift;
  logic                  push;
  logic                  pop;
  logic                  bit_end;

  // full is judged on pre-edge state, so a push while full is dropped even if a pop happens
  assign push      = wif.wr_en && !wif.full;
  assign pop       = (state == IDLE) && !wif.empty;
  assign bit_end   = (baud_cnt == BIT_END);
  assign wif.full  = (count == LVL_W'(DEPTH));
  assign wif.empty = (count == '0);

  // FIFO storage; contents need no reset because pointers and count do
  always_ff @(posedge clock_50_b7a) begin
    if (push) begin
      mem[wptr] <= wif.wr_data;
    end
  end

  // FIFO bookkeeping and the serializer
  always_ff @(posedge clock_50_b7a or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      busy     <= 1'b0;
      tx       <= 1'b1;
    end else begin
      if (push) begin
        wptr <= wptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rptr <= rptr + DEPTH_LOG2'(1);
      end
      if (push && !pop) begin
        count <= count + LVL_W'(1);
      end else if (!push && pop) begin
        count <= count - LVL_W'(1);
      end

      // tx/busy are loaded alongside each state change so they line up with the new state
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= mem[rptr];
            baud_cnt <= '0;
            state    <= START;
            busy     <= 1'b1;
            tx       <= 1'b0;
          end else begin
            busy     <= 1'b0;
            tx       <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at 10 clocks per bit, depth 4. Written bytes go into a
// scoreboard queue; a line monitor decodes each frame from tx and pops/compares.
module tb_uart_tx_fifo;

  logic clk;
  logic rst;
  logic busy;
  logic tx;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   wr_cyc;

  logic [7:0] exp_q[$];
  int         starts[$];

  uart_tx_fifo_if wif();

  uart_tx_fifo #(
    .CLK_HZ    (100),
    .BAUD      (10),
    .DEPTH_LOG2(2)
  ) dut (
    .clock_50_b7a(clk),
    .reset       (rst),
    .wif         (wif),
    .busy        (busy),
    .tx          (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Caller is aligned to a negedge; returns one negedge later with wr_en low.
  task automatic write_byte(input logic [7:0] d, input bit accepted);
    wif.wr_data = d;
    wif.wr_en   = 1'b1;
    wr_cyc      = cyc;
    if (accepted) exp_q.push_back(d);
    @(negedge clk);
    wif.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!busy && wif.empty) break;
    end
    check(tag, 32'(n < 2000), 1);
    repeat (3) @(negedge clk);
  endtask

  // Frame decoder: sample mid-bit, abort cleanly if reset hits mid-frame.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] exp;
    bit         ab;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        starts.push_back(cyc);
        ab  = 1'b0;
        got = '0;
        for (int k = 1; k <= 100; k++) begin
          @(negedge clk);
          if (rst) begin
            ab = 1'b1;
            break;
          end
          if (k == 4) check("start_bit", 32'(tx), 0);
          else if (k >= 14 && k <= 84 && (k % 10) == 4) got = {tx, got[7:1]};
          else if (k == 94) check("stop_bit", 32'(tx), 1);
          else if (k == 99) check("busy_in_frame", 32'(busy), 1);
          else if (k == 100) check("busy_after_frame", 32'(busy), 0);
        end
        if (!ab) begin
          check("frame_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("frame_byte", 32'(got), 32'(exp));
          end
        end
      end
    end
  end

  initial begin : stim
    int  n0;
    int  lim;
    bit  seen_low;
    n_cmp = 0;
    n_err = 0;
    wr_cyc = 0;
    wif.wr_en   = 1'b0;
    wif.wr_data = '0;
    rst = 1'b0;

    // Reset takes effect before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_empty", 32'(wif.empty), 1);
    check("rst_full", 32'(wif.full), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte, latency and frame shape
    write_byte(8'h55, 1'b1);
    wait_idle("idle_single");
    check("latency", 32'(starts[$] - wr_cyc), 2);

    // Back-to-back frames separated by one idle clock
    n0 = starts.size();
    write_byte(8'hA3, 1'b1);
    write_byte(8'h0F, 1'b1);
    for (lim = 0; lim < 400 && starts.size() < n0 + 2; lim++) @(negedge clk);
    check("b2b_second_start", 32'(starts.size() >= n0 + 2), 1);
    check("b2b_empty", 32'(wif.empty), 1);
    wait_idle("idle_b2b");
    if (starts.size() >= n0 + 2) check("b2b_gap", 32'(starts[n0+1] - starts[n0]), 101);

    // Overflow while the shifter is busy
    write_byte(8'hEE, 1'b1);
    repeat (2) @(negedge clk);
    check("ovf_busy", 32'(busy), 1);
    write_byte(8'h01, 1'b1);
    write_byte(8'h02, 1'b1);
    write_byte(8'h03, 1'b1);
    check("full_after3", 32'(wif.full), 0);
    write_byte(8'h04, 1'b1);
    check("full_after4", 32'(wif.full), 1);
    write_byte(8'h05, 1'b0);
    check("full_after5", 32'(wif.full), 1);
    wait_idle("idle_ovf");

    // Push in the same cycle as the pop of a single queued byte
    write_byte(8'h11, 1'b1);
    write_byte(8'h7E, 1'b1);
    check("coll_not_empty", 32'(wif.empty), 0);
    check("coll_not_full", 32'(wif.full), 0);
    @(negedge clk);
    check("coll_busy", 32'(busy), 1);
    wait_idle("idle_coll");

    // Reset during DATA bit 3 of 0xFF with two bytes queued
    n0 = starts.size();
    write_byte(8'hFF, 1'b1);
    write_byte(8'h12, 1'b1);
    write_byte(8'h34, 1'b1);
    for (lim = 0; lim < 200 && starts.size() <= n0; lim++) @(negedge clk);
    check("rstmid_started", 32'(starts.size() > n0), 1);
    if (starts.size() > n0) begin
      for (lim = 0; lim < 200 && cyc < starts[n0] + 43; lim++) @(negedge clk);
    end
    check("rstmid_in_data", 32'(tx), 1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("rstmid_tx", 32'(tx), 1);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_empty", 32'(wif.empty), 1);
    check("rstmid_full", 32'(wif.full), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n0 = starts.size();
    seen_low = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) seen_low = 1'b1;
    end
    check("rstmid_quiet", 32'(seen_low), 0);
    check("rstmid_no_frame", 32'(starts.size() - n0), 0);

    // Block resumes with a fresh write
    write_byte(8'h5A, 1'b1);
    wait_idle("idle_resume");
    check("resume_latency", 32'(starts[$] - wr_cyc), 2);

    check("sb_leftover", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
